mhsa_usram_sched: RTL

Sequencer and access arbiter for the 64-bit usram shared between the ICB interface unit and the MHSA compute engine. A rising edge on the CSR start bit launches one job, in order:
- LOAD: stream LOAD_WORDS words from input_base to the engine.
- COMPUTE: pulse the engine start, wait for engine done.
- STORE: write STORE_WORDS result words to output_base.
- Finish: raise done.

Outside a job the ICB host owns the usram.

---
 rtl/mhsa_pkg.sv | 14 +
 rtl/usram_port_mux.sv | 35 +++
 rtl/mhsa_usram_sched.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/mhsa_pkg.sv
// Shared types and constants for the MHSA usram scheduler slice.
package mhsa_pkg;

  localparam int USRAM_AW = 14;
  localparam int USRAM_DW = 64;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD    = 2'd1,
    COMPUTE = 2'd2,
    STORE   = 2'd3
  } sched_state_e;

endpackage

// File: rtl/usram_port_mux.sv
// usram owner select: host drives the port in IDLE, the scheduler otherwise.
// Host writes arriving while the scheduler owns the port are reported on host_drop.
module usram_port_mux
  import mhsa_pkg::*;
#(
  parameter int AW = USRAM_AW
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                host_sel,
  input  logic [AW-1:0]       host_addr,
  input  logic [USRAM_DW-1:0] host_wdata,
  input  logic                host_we,
  input  logic [AW-1:0]       sch_addr,
  input  logic [USRAM_DW-1:0] sch_wdata,
  input  logic                sch_we,
  output logic [AW-1:0]       sram_addr,
  output logic [USRAM_DW-1:0] sram_wdata,
  output logic                sram_we,
  output logic                host_drop
);

  assign sram_addr  = host_sel ? host_addr  : sch_addr;
  assign sram_wdata = host_sel ? host_wdata : sch_wdata;
  assign sram_we    = host_sel ? host_we    : sch_we;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      host_drop <= 1'b0;
    end else begin
      host_drop <= host_we & ~host_sel;
    end
  end

endmodule

// File: rtl/mhsa_usram_sched.sv
// Job sequencer for the shared usram: LOAD input words into the engine, run
// COMPUTE, STORE the results, then raise a sticky done.
//
// Handshakes: a load read issues in any LOAD cycle with eng_ld_ready=1 and its
// data is presented with eng_ld_valid exactly one cycle later (no back-pressure
// on delivery); a store beat transfers in any cycle with eng_st_valid &
// eng_st_ready, and is written to the usram in that same cycle.
module mhsa_usram_sched
  import mhsa_pkg::*;
#(
  parameter int LOAD_WORDS  = 64,
  parameter int STORE_WORDS = 64,
  parameter int AW          = USRAM_AW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [31:0]   csr_start,
  input  logic [31:0]   csr_input_base,
  input  logic [31:0]   csr_output_base,
  input  logic [31:0]   host_addr,
  input  logic [63:0]   host_wdata,
  input  logic          host_we,
  output logic [63:0]   host_rdata,
  output logic          host_drop,
  output logic [AW-1:0] sram_addr,
  output logic [63:0]   sram_wdata,
  output logic          sram_we,
  input  logic [63:0]   sram_rdata,
  input  logic          eng_ld_ready,
  output logic          eng_ld_valid,
  output logic [63:0]   eng_ld_data,
  output logic          eng_start,
  input  logic          eng_done,
  input  logic          eng_st_valid,
  input  logic [63:0]   eng_st_data,
  output logic          eng_st_ready,
  output logic          busy,
  output logic          done,
  output logic [1:0]    dbg_state
);

  localparam logic [14:0] LD_LAST = 15'(LOAD_WORDS - 1);
  localparam logic [14:0] ST_LAST = 15'(STORE_WORDS - 1);

  sched_state_e  state;
  logic          start_q;
  logic [AW-1:0] in_base;
  logic [AW-1:0] out_base;
  logic [14:0]   rd_cnt;
  logic [14:0]   wr_cnt;
  logic [AW-1:0] sch_addr;
  logic          sch_we;
  logic          unused_bits;

  assign unused_bits = ^{csr_start[31:1], csr_input_base[31:AW],
                         csr_output_base[31:AW], host_addr[31:AW]};

  // Offsets are added in AW bits so the block wraps around the top of the usram.
  always_comb begin
    sch_addr = in_base + rd_cnt[AW-1:0];
    if (state == STORE) begin
      sch_addr = out_base + wr_cnt[AW-1:0];
    end
  end

  assign sch_we       = (state == STORE) && eng_st_valid;
  assign eng_st_ready = (state == STORE);
  assign busy         = (state != IDLE);
  assign eng_ld_data  = sram_rdata;
  assign host_rdata   = sram_rdata;
  assign dbg_state    = state;

  usram_port_mux #(.AW(AW)) u_port_mux (
    .clk        (clk),
    .rst_n      (rst_n),
    .host_sel   (state == IDLE),
    .host_addr  (host_addr[AW-1:0]),
    .host_wdata (host_wdata),
    .host_we    (host_we),
    .sch_addr   (sch_addr),
    .sch_wdata  (eng_st_data),
    .sch_we     (sch_we),
    .sram_addr  (sram_addr),
    .sram_wdata (sram_wdata),
    .sram_we    (sram_we),
    .host_drop  (host_drop)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      start_q      <= 1'b0;
      in_base      <= '0;
      out_base     <= '0;
      rd_cnt       <= '0;
      wr_cnt       <= '0;
      eng_ld_valid <= 1'b0;
      eng_start    <= 1'b0;
      done         <= 1'b0;
    end else begin
      start_q      <= csr_start[0];
      eng_ld_valid <= 1'b0;
      eng_start    <= 1'b0;
      case (state)
        IDLE: begin
          if (csr_start[0] && !start_q) begin
            state    <= LOAD;
            in_base  <= csr_input_base[AW-1:0];
            out_base <= csr_output_base[AW-1:0];
            rd_cnt   <= '0;
            wr_cnt   <= '0;
            done     <= 1'b0;
          end
        end
        LOAD: begin
          if (eng_ld_ready) begin
            eng_ld_valid <= 1'b1;
            rd_cnt       <= rd_cnt + 15'd1;
            // The last word's data and the compute start land in the same cycle.
            if (rd_cnt == LD_LAST) begin
              state     <= COMPUTE;
              eng_start <= 1'b1;
            end
          end
        end
        COMPUTE: begin
          if (eng_done) begin
            state <= STORE;
          end
        end
        STORE: begin
          if (eng_st_valid) begin
            wr_cnt <= wr_cnt + 15'd1;
            if (wr_cnt == ST_LAST) begin
              state <= IDLE;
              done  <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
